// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between N_REQ writeback
// sources, each with a one-entry holding buffer. x0 writes are dropped on acceptance.
module regfile_write_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic                      wb_en,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic [DATA_W-1:0]         wb_data,
    output logic [(2**ADDR_W)-1:0]    pending_mask,
    output logic                      busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  held;
    logic [N_REQ-1:0]  held_next;
    logic [N_REQ-1:0]  take;
    logic [N_REQ-1:0]  grant;
    logic [ADDR_W-1:0] hold_addr [N_REQ];
    logic [DATA_W-1:0] hold_data [N_REQ];
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  idx;
    logic [PTR_W:0]    sum;
    logic              any_grant;

    // Scan held[] from rr_ptr upward with wrap-around; first hit wins.
    always_comb begin
        grant     = '0;
        win       = '0;
        any_grant = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            sum = {1'b0, rr_ptr} + (PTR_W + 1)'(off);
            if (sum >= (PTR_W + 1)'(N_REQ)) begin
                sum = sum - (PTR_W + 1)'(N_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!any_grant && held[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
    end

    assign req_ready = ~held | grant;
    assign busy      = |held;

    always_comb begin
        take      = '0;
        held_next = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            take[i] = req_valid[i] && req_ready[i] &&
                      (req_addr[i*ADDR_W +: ADDR_W] != '0);
            // Grant clears first so a same-cycle capture re-arms the slot.
            held_next[i] = (held[i] && !grant[i]) || take[i];
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (held[i]) begin
                pending_mask[hold_addr[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held    <= '0;
            rr_ptr  <= '0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            held  <= held_next;
            wb_en <= any_grant;
            if (any_grant) begin
                wb_addr <= hold_addr[win];
                wb_data <= hold_data[win];
                rr_ptr  <= (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (take[i]) begin
                hold_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
                hold_data[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, streaming sequence,
// and randomized traffic checked against a behavioural model.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic [31:0]       pending_mask;
    logic              busy;

    regfile_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .pending_mask(pending_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one slot per requester plus a rotating priority start.
    bit            m_held [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    int            m_ptr;
    bit            m_wb_en;
    logic [AW-1:0] m_wb_addr;
    logic [DW-1:0] m_wb_data;

    function automatic int m_winner();
        for (int k = 0; k < N; k++) begin
            if (m_held[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int w;
        w = m_winner();
        for (int i = 0; i < N; i++) r[i] = !m_held[i] || (w == i);
        return r;
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < N; i++) if (m_held[i]) p[m_addr[i]] = 1'b1;
        return p;
    endfunction

    task automatic model_edge(input bit rst, input logic [N-1:0] v,
                              input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        int w;
        logic [N-1:0] rdy;
        if (rst) begin
            for (int i = 0; i < N; i++) m_held[i] = 1'b0;
            m_ptr = 0; m_wb_en = 1'b0; m_wb_addr = '0; m_wb_data = '0;
        end else begin
            w   = m_winner();
            rdy = m_ready();
            m_wb_en = (w >= 0);
            if (w >= 0) begin
                m_wb_addr = m_addr[w];
                m_wb_data = m_data[w];
                m_held[w] = 1'b0;
                m_ptr     = (w + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && rdy[i] && a[i*AW +: AW] != 0) begin
                    m_held[i] = 1'b1;
                    m_addr[i] = a[i*AW +: AW];
                    m_data[i] = d[i*DW +: DW];
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input logic [N-1:0] v,
                         input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        reset = rst; req_valid = v; req_addr = a; req_data = d;
        @(posedge clk);
        model_edge(rst, v, a, d);
        @(negedge clk);
        chk("m_ready",   64'(req_ready),    64'(m_ready()));
        chk("m_wb_en",   64'(wb_en),        64'(m_wb_en));
        chk("m_wb_addr", 64'(wb_addr),      64'(m_wb_addr));
        chk("m_wb_data", 64'(wb_data),      64'(m_wb_data));
        chk("m_pending", 64'(pending_mask), 64'(m_pending()));
        chk("m_busy",    64'(busy),         64'(m_held[0] || m_held[1] || m_held[2]));
    endtask

    typedef struct {
        bit          rst;
        logic [2:0]  v;
        logic [14:0] a;
        logic [95:0] d;
        logic [2:0]  ready;
        bit          wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pend;
        bit          busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [2:0] v, logic [4:0] a0, logic [4:0] a1,
                                logic [4:0] a2, logic [31:0] d0, logic [31:0] d1,
                                logic [31:0] d2, logic [2:0] rdy, bit wen, logic [4:0] wa,
                                logic [31:0] wd, logic [31:0] pend, bit bsy);
        vec_t t;
        t.rst = rst; t.v = v; t.a = {a2, a1, a0}; t.d = {d2, d1, d0};
        t.ready = rdy; t.wen = wen; t.wa = wa; t.wd = wd; t.pend = pend; t.busy = bsy;
        return t;
    endfunction

    logic [AW-1:0] stream_q[$];
    logic [N-1:0]  rv, rdy;
    logic [N*AW-1:0] ra;
    logic [N*DW-1:0] rd;
    int k;

    initial begin
        reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;

        // Expected outputs are those seen after the edge that consumed the row.
        tbl.push_back(mk(1, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 0,  0, 0,            32'h0,    0));
        tbl.push_back(mk(0, 3'b001,  5, 0, 0, 32'hDEADBEEF, 0, 0,      3'b111, 0,  0, 0,            32'h20,   1));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 1,  5, 32'hDEADBEEF, 32'h0,    0));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 0,  5, 32'hDEADBEEF, 32'h0,    0));
        tbl.push_back(mk(0, 3'b010,  0, 0, 0, 0, 32'h1234, 0,          3'b111, 0,  5, 32'hDEADBEEF, 32'h0,    0));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 0,  5, 32'hDEADBEEF, 32'h0,    0));
        tbl.push_back(mk(1, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 0,  0, 0,            32'h0,    0));
        tbl.push_back(mk(0, 3'b111,  1, 2, 3, 32'h11, 32'h22, 32'h33,  3'b001, 0,  0, 0,            32'hE,    1));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b011, 1,  1, 32'h11,       32'hC,    1));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 1,  2, 32'h22,       32'h8,    1));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 1,  3, 32'h33,       32'h0,    0));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 0,  3, 32'h33,       32'h0,    0));
        tbl.push_back(mk(0, 3'b010,  0, 7, 0, 0, 32'h77, 0,            3'b111, 0,  3, 32'h33,       32'h80,   1));
        tbl.push_back(mk(0, 3'b111,  1, 2, 3, 32'h44, 32'h55, 32'h66,  3'b100, 1,  7, 32'h77,       32'hE,    1));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b101, 1,  3, 32'h66,       32'h6,    1));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 1,  1, 32'h44,       32'h4,    1));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 1,  2, 32'h55,       32'h0,    0));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 0,  2, 32'h55,       32'h0,    0));
        tbl.push_back(mk(0, 3'b001, 10, 0, 0, 32'hA0, 0, 0,            3'b111, 0,  2, 32'h55,       32'h400,  1));
        tbl.push_back(mk(0, 3'b001, 11, 0, 0, 32'hA1, 0, 0,            3'b111, 1, 10, 32'hA0,       32'h800,  1));
        tbl.push_back(mk(0, 3'b001, 12, 0, 0, 32'hA2, 0, 0,            3'b111, 1, 11, 32'hA1,       32'h1000, 1));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 1, 12, 32'hA2,       32'h0,    0));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 0, 12, 32'hA2,       32'h0,    0));
        tbl.push_back(mk(0, 3'b111,  4, 5, 6, 32'h1, 32'h2, 32'h3,     3'b010, 0, 12, 32'hA2,       32'h70,   1));
        tbl.push_back(mk(1, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 0,  0, 0,            32'h0,    0));
        tbl.push_back(mk(0, 3'b000,  0, 0, 0, 0, 0, 0,                 3'b111, 0,  0, 0,            32'h0,    0));

        foreach (tbl[r]) begin
            cycle(tbl[r].rst, tbl[r].v, tbl[r].a, tbl[r].d);
            chk($sformatf("v%0d_ready", r), 64'(req_ready),    64'(tbl[r].ready));
            chk($sformatf("v%0d_wb_en", r), 64'(wb_en),        64'(tbl[r].wen));
            chk($sformatf("v%0d_wb_addr", r), 64'(wb_addr),    64'(tbl[r].wa));
            chk($sformatf("v%0d_wb_data", r), 64'(wb_data),    64'(tbl[r].wd));
            chk($sformatf("v%0d_pending", r), 64'(pending_mask), 64'(tbl[r].pend));
            chk($sformatf("v%0d_busy", r), 64'(busy),          64'(tbl[r].busy));
        end

        // Streaming: req0 sends addrs 1..8 while req1 keeps its slot occupied.
        cycle(1'b1, '0, '0, '0);
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            rv  = {1'b0, 1'b1, 1'b1};
            ra  = {5'd0, 5'd20, 5'(k + 1)};
            rd  = {32'h0, 32'h1000_0014, 32'(k + 1)};
            rdy = m_ready();
            cycle(1'b0, rv, ra, rd);
            if (rdy[0]) k++;
            if (wb_en && wb_data[31:28] == 4'h0) stream_q.push_back(wb_addr);
        end
        chk("stream_accepted", 64'(k), 64'(8));
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, '0, '0, '0);
            if (wb_en && wb_data[31:28] == 4'h0) stream_q.push_back(wb_addr);
        end
        chk("stream_count", 64'(stream_q.size()), 64'(8));
        for (int i = 0; i < 8 && i < stream_q.size(); i++) begin
            chk($sformatf("stream_order%0d", i), 64'(stream_q[i]), 64'(i + 1));
        end

        // Randomized traffic; a stalled requester keeps addr/data stable.
        cycle(1'b1, '0, '0, '0);
        rv = '0; ra = '0; rd = '0; rdy = '1;
        for (int c = 0; c < 500; c++) begin
            bit rst;
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (!(rv[i] && !rdy[i])) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    ra[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    rd[i*DW +: DW] = $urandom;
                end
            end
            rdy = m_ready();
            cycle(rst, rv, ra, rd);
            if (rst) rdy = '1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (writeRegister / writeData / regWrite) between N_REQ writeback sources, e.g. ALU, load unit and multiplier.
- Each source has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains one buffered write per cycle into registered write-port outputs.
- Writes to x0 are discarded, and a pending-register bitmask is exported for hazard/stall logic.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  bit i: requester i presents a write this cycle.
- req_ready  output  N_REQ  bit i: requester i's buffer can accept this cycle.
- req_addr  input  N_REQ*ADDR_W  slice i = bits [i*ADDR_W +: ADDR_W], destination register.
- req_data  input  N_REQ*DATA_W  slice i = bits [i*DATA_W +: DATA_W], write data.
- wb_en  output  1  drives regWrite.
- wb_addr  output  ADDR_W  drives writeRegister.
- wb_data  output  DATA_W  drives writeData.
- pending_mask  output  2**ADDR_W  bit r is set while any held entry targets register r.
- busy  output  1  OR of all held flags.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). reset is sampled only on the rising edge of clk.
- State per requester i:
  - held[i], hold_addr[i], hold_data[i].
  - Global rr_ptr, range 0..N_REQ-1.
- Reset values:
  - held = 0, rr_ptr = 0.
  - wb_en = 0, wb_addr = 0, wb_data = 0.
  - Therefore req_ready = all ones (since no buffer is held), pending_mask = 0, busy = 0.
- Handshake:
  - req_ready[i] = !held[i] || grant[i]. It is combinational from state only and never depends on req_valid.
  - Transfer occurs when req_valid[i] && req_ready[i] at a rising edge.
  - The requester must hold addr/data stable while valid && !ready.
- x0 handling:
  - A transfer with req_addr slice == 0 is accepted but not buffered.
  - held[i] is unchanged by it (cleared if granted that same cycle), and wb_en is never asserted for addr 0.
- Arbitration (combinational, each cycle):
  - Search held[] starting at index rr_ptr, ascending, with wrap-around mod N_REQ.
  - The first set bit is the winner: grant is one-hot, or zero if nothing is held.
- On each edge with a grant to winner w:
  - wb_en <= 1, wb_addr <= hold_addr[w], wb_data <= hold_data[w].
  - held[w] cleared, rr_ptr <= (w+1) mod N_REQ.
- On each edge with no grant:
  - wb_en <= 0; wb_addr and wb_data hold their previous values.
  - rr_ptr is unchanged.
- Simultaneous grant[i] and new transfer on i: the old entry goes to wb; the new entry is captured into held[i] (held stays 1). Sustained throughput is 1 write per cycle per port when uncontended.
- Latency:
  - Transfer accepted at edge E, uncontended: wb_en is high during the cycle after edge E+1.
  - The register file commits at edge E+2.
  - Worst-case wait is N_REQ-1 extra cycles (round-robin is starvation-free).
- pending_mask: bit r = OR over i of (held[i] && hold_addr[i]==r). Combinational from held state; it does not include the entry currently on wb_*.
- Same-register writes from different requesters: the arbiter does not order them. Upstream stalls using pending_mask.
- Reset mid-operation: all held entries are discarded, no write is issued, and wb_en is 0 in the cycle after the reset edge.

Test Plan:
- Reset, then a single write: req0 addr=5 data=0xDEADBEEF valid 1 cycle -> wb_en=1, wb_addr=5, wb_data=0xDEADBEEF exactly one cycle, two edges after acceptance. pending_mask[5] is high for one cycle.
- x0 drop: req1 addr=0 data=0x1234 -> req_ready[1] stays 1, wb_en never asserts, pending_mask stays 0.
- Contention, round-robin:
  - Stimulus: req0, req1 and req2 accepted on the same edge with addrs 1, 2, 3.
  - Required: wb_addr sequence is 1, 2, 3 on consecutive cycles, and rr_ptr = 0 afterwards.
  - Repeat the stimulus with rr_ptr = 2 at start: required wb_addr order is 3, 1, 2.
- Back-pressure / streaming:
  - Stimulus: req0 valid every cycle, addrs 1..8, while req1 is held busy.
  - Required: req_ready[0] drops only on cycles where req0 loses arbitration, all 8 writes emerge in order, and none are lost or duplicated.
- Simultaneous grant and capture: req0 streams addrs 10, 11, 12 with no contention -> wb_en high on 3 consecutive cycles, and req_ready[0] stays 1 throughout.
- Reset mid-operation: three entries held, assert reset for 1 edge -> held cleared, wb_en=0 the next cycle, no write to the held addrs ever appears, and req_ready = 3'b111.
